seq_detect_ctrl: RTL and testbench
==================================

Name: seq_detect_ctrl

Overview:
- Programmable serial pattern-detection controller.
- Holds a loadable pattern (1..MAX_LEN bits) and a match target, and arms and disarms detection on the serial input x.
- Produces a Mealy match output y, counts matches, and signals done when the target is reached.
- Software-style configuration and start/abort sequencing sit around a generalised 1010-class Mealy detector.

Parameters:
MAX_LEN, 8, maximum pattern length in bits
CW, 8, match counter and target width
LW, 4, width of cfg_len (must hold MAX_LEN)

Ports:
clk  in  1  system clock, rising edge
rst  in  1  synchronous, active-high reset
cfg_valid  in  1  configuration offer
cfg_ready  out  1  configuration accepted when high with cfg_valid
cfg_pattern  in  MAX_LEN  pattern bits; bit [len-1] is the first serial bit expected
cfg_len  in  LW  pattern length
cfg_target  in  CW  matches before done; 0 = run indefinitely
start  in  1  arm detection
abort  in  1  disarm detection
x  in  1  serial data, one bit per clk
y  out  1  Mealy match indication (combinational)
busy  out  1  high in RUN
done  out  1  high in DONE
match_count  out  CW  matches in current or last run

Behaviour:
- One clock domain (clk). Reset is synchronous and active-high on rst.
- Reset values:
  - state IDLE; y=0, busy=0, done=0, match_count=0, cfg_ready=1.
  - pattern=8'b0000_1010, len=4, target=0, history=0, fill=0.
- States: IDLE, RUN, DONE.
- cfg_ready = (state != RUN). Handshake completes when cfg_valid && cfg_ready; pattern, len and target register on that edge.
- cfg_len of 0 or greater than MAX_LEN is stored as MAX_LEN.
- IDLE/DONE -> RUN on start (and !abort). On that edge: match_count=0, history=0, fill=0, done deasserts.
  - x is first sampled in the first RUN cycle.
  - If cfg handshake and start occur in the same cycle, the run uses the new configuration.
- RUN, every cycle:
  - y = (fill >= len-1) && ({history[len-2:0], x} == pattern[len-1:0]). For len=1: y = (x == pattern[0]).
  - Edge: history <= {history[MAX_LEN-2:0], x}; fill increments, saturating at MAX_LEN.
  - On y: match_count increments, saturating at 2^CW-1.
- RUN -> DONE on the edge where y=1 and target != 0 and match_count+1 == target.
  - match_count shows target in DONE.
  - y is forced to 0 outside RUN.
- RUN -> IDLE on abort. match_count is retained.
- abort has priority over start and over a completing match in the same cycle. In that case the count still increments, but the state goes to IDLE, not DONE.
- start while in RUN: ignored.
- abort in IDLE/DONE: DONE -> IDLE, done clears. In IDLE there is no effect.
- Default mode is overlapping: history is not cleared on a match.
- rst mid-run: returns to IDLE with reset configuration; any in-progress count is lost.
- Latency: y is asserted in the same cycle as the last pattern bit on x. match_count, state and done update at the following edge.

Optional Feature:
- Macro: SEQ_DETECT_NONOVERLAP_EN.
- Defined: on every RUN edge with y=1, fill resets to 0, so the next match requires len fresh bits (non-overlapping detection). history still shifts.
- Undefined: overlapping detection as described above.

Test Plan:
- After rst, cfg untouched, start, x=1,0,1,0,1,0,1,0 -> y high on bits 4, 6 and 8; match_count=3; busy=1, done=0.
  - With SEQ_DETECT_NONOVERLAP_EN: y high on bits 4 and 8 only; match_count=2.
- cfg pattern=1010, len=4, target=2; start; x=1,0,1,0,1,0,1,0 -> y on bits 4 and 6; DONE entered after bit 6; done=1, match_count=2; y=0 for bits 7-8.
- cfg pattern=0000, len=4; start; x=0,0,0,0 -> no y on bits 1-3 (fill guard); y=1 on bit 4.
- In RUN, pulse cfg_valid -> cfg_ready=0, pattern unchanged. abort with a simultaneous final match (target=1) -> state IDLE, done=0, match_count=1.
- cfg len=1, pattern=1; start; x=1,1,0,1 -> y=1,1,0,1; match_count=3.
- cfg_len=0 with pattern=0xA5 -> len stored as 8; start; x=1,0,1,0,0,1,0,1 -> y only on bit 8.
- rst asserted mid-run with match_count=2 -> next cycle IDLE, match_count=0, pattern back to 1010 len 4.

Source files
------------

// File: rtl/seq_detect_ctrl_if.sv
// Configuration, control and serial-data bundle for seq_detect_ctrl.
// master drives configuration/control/data; slave is the detector.
interface seq_detect_ctrl_if #(
  parameter int unsigned MAX_LEN = 8,
  parameter int unsigned CW      = 8,
  parameter int unsigned LW      = 4
);
  logic               cfg_valid;
  logic               cfg_ready;
  logic [MAX_LEN-1:0] cfg_pattern;
  logic [LW-1:0]      cfg_len;
  logic [CW-1:0]      cfg_target;
  logic               start;
  logic               abort;
  logic               x;
  logic               y;
  logic               busy;
  logic               done;
  logic [CW-1:0]      match_count;

  modport master (
    output cfg_valid, cfg_pattern, cfg_len, cfg_target, start, abort, x,
    input  cfg_ready, y, busy, done, match_count
  );

  modport slave (
    input  cfg_valid, cfg_pattern, cfg_len, cfg_target, start, abort, x,
    output cfg_ready, y, busy, done, match_count
  );
endinterface

// File: rtl/seq_detect_ctrl.sv
// Programmable serial pattern detector with match counting and start/abort sequencing.
// Define SEQ_DETECT_NONOVERLAP_EN for non-overlapping detection.
module seq_detect_ctrl #(
  parameter int unsigned MAX_LEN = 8,
  parameter int unsigned CW      = 8,
  parameter int unsigned LW      = 4
) (
  input logic                clk,
  input logic                rst,
  seq_detect_ctrl_if.slave   bus
);

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e             r_state;
  state_e             w_state_nxt;
  logic [MAX_LEN-1:0] r_pattern;
  logic [LW-1:0]      r_len;
  logic [CW-1:0]      r_target;
  logic [MAX_LEN-1:0] r_hist;
  logic [LW-1:0]      r_fill;
  logic [CW-1:0]      r_count;

  logic [MAX_LEN-1:0] w_window;
  logic [MAX_LEN-1:0] w_mask;
  logic               w_hit;
  logic               w_y;
  logic               w_cfg_fire;
  logic               w_arm;
  logic [CW-1:0]      w_count_inc;
  logic [LW-1:0]      w_len_in;

  assign w_window    = {r_hist[MAX_LEN-2:0], bus.x};
  assign w_count_inc = r_count + CW'(1);
  assign w_cfg_fire  = bus.cfg_valid && (r_state != StRun);
  assign w_arm       = (r_state != StRun) && bus.start && !bus.abort;

  // Out-of-range lengths fall back to the full window.
  assign w_len_in = ((bus.cfg_len == '0) || (int'(bus.cfg_len) > int'(MAX_LEN))) ?
                    LW'(MAX_LEN) : bus.cfg_len;

  always_comb begin
    w_mask = '0;
    for (int i = 0; i < int'(MAX_LEN); i++) begin
      if (i < int'(r_len)) w_mask[i] = 1'b1;
    end
  end

  // Fill guard: at least len-1 history bits must precede the current x.
  assign w_hit = (((w_window ^ r_pattern) & w_mask) == '0) &&
                 ((int'(r_fill) + 1) >= int'(r_len));
  assign w_y   = (r_state == StRun) && w_hit;

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      StIdle: begin
        if (bus.start && !bus.abort) w_state_nxt = StRun;
      end
      StRun: begin
        if (bus.abort) begin
          w_state_nxt = StIdle;
        end else if (w_y && (r_target != '0) && (w_count_inc == r_target)) begin
          w_state_nxt = StDone;
        end
      end
      StDone: begin
        if (bus.abort)      w_state_nxt = StIdle;
        else if (bus.start) w_state_nxt = StRun;
      end
      default: w_state_nxt = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= StIdle;
      r_pattern <= MAX_LEN'(4'b1010);
      r_len     <= LW'(4);
      r_target  <= '0;
      r_hist    <= '0;
      r_fill    <= '0;
      r_count   <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_cfg_fire) begin
        r_pattern <= bus.cfg_pattern;
        r_len     <= w_len_in;
        r_target  <= bus.cfg_target;
      end
      if (w_arm) begin
        r_count <= '0;
        r_hist  <= '0;
        r_fill  <= '0;
      end else if (r_state == StRun) begin
        r_hist <= w_window;
        if (w_y && (r_count != {CW{1'b1}})) r_count <= w_count_inc;
`ifdef SEQ_DETECT_NONOVERLAP_EN
        if (w_y) begin
          r_fill <= '0;
        end else if (r_fill < LW'(MAX_LEN)) begin
          r_fill <= r_fill + LW'(1);
        end
`else
        if (r_fill < LW'(MAX_LEN)) r_fill <= r_fill + LW'(1);
`endif
      end
    end
  end

  assign bus.y           = w_y;
  assign bus.busy        = (r_state == StRun);
  assign bus.done        = (r_state == StDone);
  assign bus.cfg_ready   = (r_state != StRun);
  assign bus.match_count = r_count;

endmodule

// File: tb/tb_seq_detect_ctrl.sv
// Directed, table-driven bench for seq_detect_ctrl.
module tb_seq_detect_ctrl;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  seq_detect_ctrl_if #(.MAX_LEN(8), .CW(8), .LW(4)) bus ();

  seq_detect_ctrl #(.MAX_LEN(8), .CW(8), .LW(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    logic       x;
    logic       y;
    logic       busy;
    logic       done;
    logic [7:0] cnt;
  } vec_t;

  vec_t tbl[$];
  int   n_checks = 0;
  int   n_errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic void add(input logic x, input logic y, input logic b, input logic d,
                              input logic [7:0] c);
    vec_t v;
    v.x = x; v.y = y; v.busy = b; v.done = d; v.cnt = c;
    tbl.push_back(v);
  endfunction

  task automatic cyc();
    @(negedge clk);
  endtask

  task automatic run_seg(input int lo, input int hi, input string tag);
    for (int i = lo; i < hi; i++) begin
      bus.x = tbl[i].x;
      #1;
      chk($sformatf("%s[%0d].y", tag, i - lo), {31'b0, bus.y}, {31'b0, tbl[i].y});
      chk($sformatf("%s[%0d].busy", tag, i - lo), {31'b0, bus.busy}, {31'b0, tbl[i].busy});
      chk($sformatf("%s[%0d].done", tag, i - lo), {31'b0, bus.done}, {31'b0, tbl[i].done});
      chk($sformatf("%s[%0d].cnt", tag, i - lo), {24'b0, bus.match_count}, {24'b0, tbl[i].cnt});
      cyc();
    end
  endtask

  task automatic do_start();
    bus.x = 1'b0; bus.start = 1'b1; cyc(); bus.start = 1'b0;
  endtask

  task automatic do_abort();
    bus.abort = 1'b1; cyc(); bus.abort = 1'b0;
  endtask

  task automatic do_cfg(input logic [7:0] p, input logic [3:0] l, input logic [7:0] t);
    bus.cfg_valid = 1'b1; bus.cfg_pattern = p; bus.cfg_len = l; bus.cfg_target = t;
    cyc();
    bus.cfg_valid = 1'b0;
  endtask

  task automatic post(input string tag, input logic b, input logic d, input logic [7:0] c);
    #1;
    chk({tag, ".busy"}, {31'b0, bus.busy}, {31'b0, b});
    chk({tag, ".done"}, {31'b0, bus.done}, {31'b0, d});
    chk({tag, ".cnt"}, {24'b0, bus.match_count}, {24'b0, c});
  endtask

  int s1, s2, s3, s5, s6, s7a, s7b, e7;

  initial begin
    // Vector tables: {x, y, busy, done, count before the edge}.
    s1 = tbl.size();
    add(1, 0, 1, 0, 0); add(0, 0, 1, 0, 0); add(1, 0, 1, 0, 0); add(0, 1, 1, 0, 0);
`ifdef SEQ_DETECT_NONOVERLAP_EN
    add(1, 0, 1, 0, 1); add(0, 0, 1, 0, 1); add(1, 0, 1, 0, 1); add(0, 1, 1, 0, 1);
`else
    add(1, 0, 1, 0, 1); add(0, 1, 1, 0, 1); add(1, 0, 1, 0, 2); add(0, 1, 1, 0, 2);
`endif
    s2 = tbl.size();
    add(1, 0, 1, 0, 0); add(0, 0, 1, 0, 0); add(1, 0, 1, 0, 0); add(0, 1, 1, 0, 0);
`ifdef SEQ_DETECT_NONOVERLAP_EN
    add(1, 0, 1, 0, 1); add(0, 0, 1, 0, 1); add(1, 0, 1, 0, 1); add(0, 1, 1, 0, 1);
    add(1, 0, 0, 1, 2); add(0, 0, 0, 1, 2);
`else
    add(1, 0, 1, 0, 1); add(0, 1, 1, 0, 1); add(1, 0, 0, 1, 2); add(0, 0, 0, 1, 2);
`endif
    s3 = tbl.size();
    add(0, 0, 1, 0, 0); add(0, 0, 1, 0, 0); add(0, 0, 1, 0, 0); add(0, 1, 1, 0, 0);
    s5 = tbl.size();
    add(1, 1, 1, 0, 0); add(1, 1, 1, 0, 1); add(0, 0, 1, 0, 2); add(1, 1, 1, 0, 2);
    s6 = tbl.size();
    add(1, 0, 1, 0, 0); add(0, 0, 1, 0, 0); add(1, 0, 1, 0, 0); add(0, 0, 1, 0, 0);
    add(0, 0, 1, 0, 0); add(1, 0, 1, 0, 0); add(0, 0, 1, 0, 0); add(1, 1, 1, 0, 0);
    s7a = tbl.size();
    add(1, 1, 1, 0, 0); add(1, 1, 1, 0, 1);
    s7b = tbl.size();
    add(1, 0, 1, 0, 0); add(0, 0, 1, 0, 0); add(1, 0, 1, 0, 0); add(0, 1, 1, 0, 0);
    e7 = tbl.size();

    bus.cfg_valid = 1'b0; bus.cfg_pattern = '0; bus.cfg_len = '0; bus.cfg_target = '0;
    bus.start = 1'b0; bus.abort = 1'b0; bus.x = 1'b0;
    rst = 1'b1;
    cyc(); cyc();
    rst = 1'b0;
    #1;
    chk("rst.cfg_ready", {31'b0, bus.cfg_ready}, 32'd1);
    chk("rst.y", {31'b0, bus.y}, 32'd0);
    post("rst", 1'b0, 1'b0, 8'd0);
    cyc();

    // Default configuration, overlapping 1010 stream.
    do_start();
    run_seg(s1, s2, "t1");
`ifdef SEQ_DETECT_NONOVERLAP_EN
    post("t1.end", 1'b1, 1'b0, 8'd2);
`else
    post("t1.end", 1'b1, 1'b0, 8'd3);
`endif
    cyc();
    do_abort();

    // Target of 2: DONE, then abort clears done and keeps the count.
    do_cfg(8'h0A, 4'd4, 8'd2);
    do_start();
    run_seg(s2, s3, "t2");
    do_abort();
    post("t2.abort", 1'b0, 1'b0, 8'd2);
    cyc();

    // All-zero pattern, configured in the same cycle as start.
    bus.cfg_valid = 1'b1; bus.cfg_pattern = 8'h00; bus.cfg_len = 4'd4; bus.cfg_target = 8'd0;
    bus.start = 1'b1; bus.x = 1'b0;
    cyc();
    bus.cfg_valid = 1'b0; bus.start = 1'b0;
    run_seg(s3, s5, "t3");
    do_abort();

    // Config ignored in RUN; abort wins over the completing match.
    do_cfg(8'h0A, 4'd4, 8'd1);
    do_start();
    bus.cfg_valid = 1'b1; bus.cfg_pattern = 8'hFF; bus.cfg_len = 4'd2; bus.cfg_target = 8'd0;
    bus.x = 1'b1;
    #1;
    chk("t4.cfg_ready", {31'b0, bus.cfg_ready}, 32'd0);
    cyc();
    bus.x = 1'b0; cyc();
    bus.x = 1'b1; cyc();
    bus.x = 1'b0; bus.abort = 1'b1;
    #1;
    chk("t4.y", {31'b0, bus.y}, 32'd1);
    cyc();
    bus.abort = 1'b0; bus.cfg_valid = 1'b0;
    post("t4.end", 1'b0, 1'b0, 8'd1);
    chk("t4.cfg_ready_idle", {31'b0, bus.cfg_ready}, 32'd1);
    cyc();

    // Single-bit pattern.
    do_cfg(8'h01, 4'd1, 8'd0);
    do_start();
    run_seg(s5, s6, "t5");
    post("t5.end", 1'b1, 1'b0, 8'd3);
    cyc();
    do_abort();

    // cfg_len of 0 is treated as the full 8 bits.
    do_cfg(8'hA5, 4'd0, 8'd0);
    do_start();
    run_seg(s6, s7a, "t6");
    post("t6.end", 1'b1, 1'b0, 8'd1);
    cyc();
    do_abort();

    // Reset mid-run restores the default configuration.
    do_cfg(8'h01, 4'd1, 8'd0);
    do_start();
    run_seg(s7a, s7b, "t7");
    post("t7.pre", 1'b1, 1'b0, 8'd2);
    cyc();
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    post("t7.rst", 1'b0, 1'b0, 8'd0);
    chk("t7.cfg_ready", {31'b0, bus.cfg_ready}, 32'd1);
    cyc();
    do_start();
    run_seg(s7b, e7, "t7.post");

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
